axi4_dma_master: RTL

AXI4 full-protocol burst copy engine that moves a block of 32-bit words from a source region to a destination region of the same memory-mapped slave. It is the master directly upstream of the AXI4 memory slave model: it drives the AR/R channels to fetch a chunk into an internal buffer, then drives AW/W/B to write that chunk back, repeating until the requested length is copied. Addresses are word indices: one beat equals one address step.

---
 rtl/axi4_dma_master.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/axi4_dma_master.sv
// AXI4 burst copy engine: reads a chunk of words from the source region into a
// local buffer, writes it back to the destination region, and repeats until the
// requested number of words has been copied. Addresses are word indices.
module axi4_dma_master #(
   parameter int ADDR_W    = 32,
   parameter int LEN_W     = 16,
   parameter int MAX_BURST = 16,
   parameter int ID_W      = 4
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ID_W-1:0]   m_axi4_arid,
   output logic [ADDR_W-1:0] m_axi4_araddr,
   output logic [7:0]        m_axi4_arlen,
   output logic [2:0]        m_axi4_arsize,
   output logic [1:0]        m_axi4_arburst,
   output logic              m_axi4_arlock,
   output logic [3:0]        m_axi4_arcache,
   output logic [2:0]        m_axi4_arprot,
   output logic [3:0]        m_axi4_arqos,
   output logic              m_axi4_aruser,
   output logic              m_axi4_arvalid,
   input  logic              m_axi4_arready,
   input  logic [ID_W-1:0]   m_axi4_rid,
   input  logic [31:0]       m_axi4_rdata,
   input  logic [1:0]        m_axi4_rresp,
   input  logic              m_axi4_rlast,
   input  logic              m_axi4_ruser,
   input  logic              m_axi4_rvalid,
   output logic              m_axi4_rready,
   output logic [ID_W-1:0]   m_axi4_awid,
   output logic [ADDR_W-1:0] m_axi4_awaddr,
   output logic [7:0]        m_axi4_awlen,
   output logic [2:0]        m_axi4_awsize,
   output logic [1:0]        m_axi4_awburst,
   output logic              m_axi4_awlock,
   output logic [3:0]        m_axi4_awcache,
   output logic [2:0]        m_axi4_awprot,
   output logic [3:0]        m_axi4_awqos,
   output logic              m_axi4_awuser,
   output logic              m_axi4_awvalid,
   input  logic              m_axi4_awready,
   output logic [31:0]       m_axi4_wdata,
   output logic [3:0]        m_axi4_wstrb,
   output logic              m_axi4_wlast,
   output logic              m_axi4_wuser,
   output logic              m_axi4_wvalid,
   input  logic              m_axi4_wready,
   input  logic [ID_W-1:0]   m_axi4_bid,
   input  logic [1:0]        m_axi4_bresp,
   input  logic              m_axi4_buser,
   input  logic              m_axi4_bvalid,
   output logic              m_axi4_bready
);

   localparam int IW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_DONE
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] src, dst, rd_base;
   logic [LEN_W-1:0]  remaining, rem_src;
   logic [CW-1:0]     chunk, next_chunk;
   logic [IW-1:0]     chunk_m1, rcnt, wcnt;
   logic              last_chunk;
   logic [31:0]       data_buf [0:MAX_BURST-1];
   logic              ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic              unused_inputs;

   assign ar_hs    = m_axi4_arvalid && m_axi4_arready;
   assign r_hs     = m_axi4_rvalid && m_axi4_rready;
   assign aw_hs    = m_axi4_awvalid && m_axi4_awready;
   assign w_hs     = m_axi4_wvalid && m_axi4_wready;
   assign b_hs     = m_axi4_bvalid && m_axi4_bready;
   assign chunk_m1 = IW'(chunk - CW'(1));

   assign m_axi4_arid    = '0;
   assign m_axi4_arsize  = 3'b010;
   assign m_axi4_arburst = 2'b01;
   assign m_axi4_arlock  = 1'b0;
   assign m_axi4_arcache = 4'h0;
   assign m_axi4_arprot  = 3'h0;
   assign m_axi4_arqos   = 4'h0;
   assign m_axi4_aruser  = 1'b0;
   assign m_axi4_awid    = '0;
   assign m_axi4_awsize  = 3'b010;
   assign m_axi4_awburst = 2'b01;
   assign m_axi4_awlock  = 1'b0;
   assign m_axi4_awcache = 4'h0;
   assign m_axi4_awprot  = 3'h0;
   assign m_axi4_awqos   = 4'h0;
   assign m_axi4_awuser  = 1'b0;
   assign m_axi4_wstrb   = 4'hF;
   assign m_axi4_wuser   = 1'b0;

   // Write data comes straight from the buffer so each W beat follows wcnt without a pipeline bubble.
   assign m_axi4_wdata = m_axi4_wvalid ? data_buf[wcnt] : '0;
   assign m_axi4_wlast = m_axi4_wvalid && (wcnt == chunk_m1);

   assign unused_inputs = ^{m_axi4_rid, m_axi4_rlast, m_axi4_ruser, m_axi4_bid, m_axi4_buser};

   // State register.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state <= S_IDLE;
      else          state <= state_next;
   end

   // Next-state logic plus sizing of the chunk that starts at the next RD_ADDR entry.
   always_comb begin
      state_next = state;
      rem_src    = (state == S_IDLE) ? len : remaining - LEN_W'(chunk);
      rd_base    = (state == S_IDLE) ? src_addr : src + ADDR_W'(chunk);
      last_chunk = (remaining == LEN_W'(chunk));
      next_chunk = (32'(rem_src) > MAX_BURST) ? CW'(MAX_BURST) : CW'(rem_src);
      case (state)
         S_IDLE:    if (start) state_next = (len == '0) ? S_DONE : S_RD_ADDR;
         S_RD_ADDR: if (ar_hs) state_next = S_RD_DATA;
         S_RD_DATA: if (r_hs && rcnt == chunk_m1) state_next = S_WR_ADDR;
         S_WR_ADDR: if (aw_hs) state_next = S_WR_DATA;
         S_WR_DATA: if (w_hs && wcnt == chunk_m1) state_next = S_WR_RESP;
         S_WR_RESP: if (b_hs) state_next = last_chunk ? S_DONE : S_RD_ADDR;
         S_DONE:    state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Registered channel controls, address/length payloads, counters and the sticky error flag.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         m_axi4_arvalid <= 1'b0;
         m_axi4_araddr  <= '0;
         m_axi4_arlen   <= '0;
         m_axi4_rready  <= 1'b0;
         m_axi4_awvalid <= 1'b0;
         m_axi4_awaddr  <= '0;
         m_axi4_awlen   <= '0;
         m_axi4_wvalid  <= 1'b0;
         m_axi4_bready  <= 1'b0;
         src            <= '0;
         dst            <= '0;
         remaining      <= '0;
         chunk          <= '0;
         rcnt           <= '0;
         wcnt           <= '0;
      end else begin
         busy           <= state_next inside {S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP};
         done           <= (state_next == S_DONE);
         m_axi4_arvalid <= (state_next == S_RD_ADDR);
         m_axi4_rready  <= (state_next == S_RD_DATA);
         m_axi4_awvalid <= (state_next == S_WR_ADDR);
         m_axi4_wvalid  <= (state_next == S_WR_DATA);
         m_axi4_bready  <= (state_next == S_WR_RESP);
         if (state == S_IDLE && start) begin
            src       <= src_addr;
            dst       <= dst_addr;
            remaining <= len;
            err       <= 1'b0;
         end
         if (state_next == S_RD_ADDR && state != S_RD_ADDR) begin
            chunk         <= next_chunk;
            m_axi4_araddr <= rd_base;
            m_axi4_arlen  <= 8'(next_chunk - CW'(1));
            rcnt          <= '0;
            wcnt          <= '0;
         end
         if (r_hs) begin
            rcnt <= rcnt + 1'b1;
            if (m_axi4_rresp != 2'b00) err <= 1'b1;
         end
         if (state_next == S_WR_ADDR && state != S_WR_ADDR) begin
            m_axi4_awaddr <= dst;
            m_axi4_awlen  <= m_axi4_arlen;
         end
         if (w_hs) wcnt <= wcnt + 1'b1;
         if (b_hs) begin
            src       <= src + ADDR_W'(chunk);
            dst       <= dst + ADDR_W'(chunk);
            remaining <= remaining - LEN_W'(chunk);
            if (m_axi4_bresp != 2'b00) err <= 1'b1;
         end
      end
   end

   // Chunk buffer captures read beats in arrival order; it needs no reset because WDATA is gated by WVALID.
   always_ff @(posedge ACLK) begin
      if (r_hs) data_buf[rcnt] <= m_axi4_rdata;
   end

endmodule
